// File: rtl/gray_cnt_pkg.sv
// Shared mode encodings and a width-agnostic binary-to-Gray helper for the counter family.
// Pure declarations: no latency, no flow control.
package gray_cnt_pkg;

  localparam int MAX_W = 32;

  localparam logic [1:0] MODE_UP_WRAP = 2'b00;
  localparam logic [1:0] MODE_DN_WRAP = 2'b01;
  localparam logic [1:0] MODE_UP_SAT  = 2'b10;
  localparam logic [1:0] MODE_DN_SAT  = 2'b11;

  // mask selects the live low bits so a single function serves every width
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                input logic [MAX_W-1:0] mask);
    logic [MAX_W-1:0] m;
    m = b & mask;
    return (m ^ (m >> 1)) & mask;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder.
// Latency 0; no flow control.
module gray_enc
  import gray_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  localparam logic [MAX_W-1:0] MASK = {MAX_W{1'b1}} >> (MAX_W - WIDTH);

  assign gray = WIDTH'(bin2gray(MAX_W'(bin), MASK));

endmodule

// File: rtl/gray_counter_n.sv
// Up/down wrap/saturate counter with registered binary, Gray and terminal-count outputs.
// Latency 1 clk; no backpressure (en gates stepping); GRAY_CNT_WRAP_FLAG_EN adds sticky wrap_flag.
module gray_counter_n
  import gray_cnt_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [1:0]       mode,
`ifdef GRAY_CNT_WRAP_FLAG_EN
  input  logic             wrap_clr,
  output logic             wrap_flag,
`endif
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             up;
  logic             sat;
  logic             at_term;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             tc_nxt;

  assign up      = (mode == MODE_UP_WRAP) || (mode == MODE_UP_SAT);
  assign sat     = (mode == MODE_UP_SAT) || (mode == MODE_DN_SAT);
  assign at_term = up ? (bin == ALL_ONES) : (bin == '0);

  always_comb begin
    bin_nxt = bin;
    tc_nxt  = 1'b0;
    if (set) begin
      bin_nxt = ALL_ONES;
    end else if (load) begin
      bin_nxt = din;
    end else if (en) begin
      tc_nxt = at_term;
      if (!(sat && at_term)) begin
        bin_nxt = up ? (bin + 1'b1) : (bin - 1'b1);
      end
    end
  end

  // Reset is folded in ahead of the encoder so gray tracks bin even on the reset edge
  assign bin_d = rst ? RST_VAL : bin_nxt;

  gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_ff @(posedge clk) begin
    bin  <= bin_d;
    gray <= gray_d;
    if (rst) tc <= 1'b0;
    else     tc <= tc_nxt;
  end

`ifdef GRAY_CNT_WRAP_FLAG_EN
  logic wrap_set;
  assign wrap_set = en && !set && !load && !sat && at_term;

  always_ff @(posedge clk) begin
    if (rst)           wrap_flag <= 1'b0;
    else if (wrap_clr) wrap_flag <= 1'b0;
    else if (wrap_set) wrap_flag <= 1'b1;
  end
`endif

endmodule
